// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: exception codes, the write-back queue entry layout
// and the width of the WS->RF bus.
package mycpu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] NO_EX = 5'h1F;
  localparam logic [4:0] INT   = 5'h00;

  // {we, waddr, wdata}
  localparam int WS_TO_RF_BUS_WD = 1 + 5 + XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            we;
    logic [4:0]      dest;
    logic [XLEN-1:0] result;
    logic [4:0]      exc;
    logic            slot;
    logic            eret;
    logic            mfc0;
    logic [XLEN-1:0] badvaddr;
  } wb_entry_t;

  // EPC points at the branch when the faulting instruction sits in its delay slot.
  function automatic logic [XLEN-1:0] epc_of(input wb_entry_t e);
    logic [XLEN-1:0] epc;
    if (e.slot) begin
      epc = e.pc - 32'd4;
    end else begin
      epc = e.pc;
    end
    return epc;
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search for one forwarding port. Slots are visited from the
// head (oldest) toward the tail so a later match overrides an earlier one.
module wb_fwd_match
  import mycpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0]        match_en,
  input  logic [DEPTH*5-1:0]      dest,
  input  logic [DEPTH*DATA_W-1:0] result,
  input  logic [DEPTH-1:0]        mfc0,
  input  logic [PTR_W-1:0]        head_ptr,
  input  logic [4:0]              raddr,
  output logic                    hit,
  output logic [DATA_W-1:0]       data,
  output logic                    stall
);

  logic [PTR_W-1:0] idx_s;

  // Age-ordered scan; register 0 is hardwired and never forwarded.
  always_comb begin
    hit   = 1'b0;
    data  = {DATA_W{1'b0}};
    stall = 1'b0;
    idx_s = head_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_ptr + PTR_W'(i);
      if (match_en[idx_s] && (dest[idx_s*5 +: 5] == raddr) && (raddr != 5'd0)) begin
        hit   = 1'b1;
        data  = result[idx_s*DATA_W +: DATA_W];
        stall = mfc0[idx_s];
      end else begin
        hit   = hit;
        data  = data;
        stall = stall;
      end
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// In-order write-back retire queue with precise exceptions/ERET at the head,
// full flush, and youngest-match forwarding to decode.
// Optional trace ports are enabled with the WB_TRACE_EN macro.
module wb_retire_queue
  import mycpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ms_to_ws_valid,
  output logic                      ws_allowin,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic                      in_we,
  input  logic [4:0]                in_dest,
  input  logic [DATA_W-1:0]         in_result,
  input  logic [4:0]                in_exc,
  input  logic                      in_slot,
  input  logic                      in_eret,
  input  logic                      in_mfc0,
  input  logic [DATA_W-1:0]         in_badvaddr,
  input  logic                      int_pending,
  input  logic                      rf_ready,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      ex_valid,
  output logic [4:0]                ex_code,
  output logic [DATA_W-1:0]         ex_epc,
  output logic [DATA_W-1:0]         ex_badvaddr,
  output logic                      ex_bd,
  output logic                      eret_valid,
  input  logic [NUM_FWD*5-1:0]      fwd_raddr,
  output logic [NUM_FWD-1:0]        fwd_hit,
  output logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [NUM_FWD-1:0]        fwd_stall,
`ifdef WB_TRACE_EN
  output logic [DATA_W-1:0]         debug_wb_pc,
  output logic [3:0]                debug_wb_rf_wen,
  output logic [4:0]                debug_wb_rf_wnum,
  output logic [DATA_W-1:0]         debug_wb_rf_wdata,
`endif
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t             entries_r [DEPTH];
  logic [DEPTH-1:0]      valid_r;
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      count_r;

  wb_entry_t             in_entry_s;
  wb_entry_t             head_s;
  logic                  head_valid_s;
  logic                  exc_take_s;
  logic                  int_take_s;
  logic                  eret_take_s;
  logic                  retire_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  flush_s;
  logic                  rf_we_s;
  logic [4:0]            rf_waddr_s;
  logic [DATA_W-1:0]     rf_wdata_s;
  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus_s;

  logic [DEPTH-1:0]        fwd_en_s;
  logic [DEPTH*5-1:0]      dest_flat_s;
  logic [DEPTH*DATA_W-1:0] result_flat_s;
  logic [DEPTH-1:0]        mfc0_flat_s;

  // Pack the incoming MEM-stage instruction into a queue entry.
  always_comb begin
    in_entry_s          = '0;
    in_entry_s.pc       = in_pc;
    in_entry_s.we       = in_we;
    in_entry_s.dest     = in_dest;
    in_entry_s.result   = in_result;
    in_entry_s.exc      = in_exc;
    in_entry_s.slot     = in_slot;
    in_entry_s.eret     = in_eret;
    in_entry_s.mfc0     = in_mfc0;
    in_entry_s.badvaddr = in_badvaddr;
  end

  // Head decision: interrupt/exception beat ERET, which beats a normal retire.
  always_comb begin
    head_s       = entries_r[head_r];
    head_valid_s = (count_r != {CNT_W{1'b0}});
    exc_take_s   = head_valid_s && (head_s.exc != NO_EX);
    int_take_s   = head_valid_s && int_pending && (head_s.exc == NO_EX) && !head_s.eret;
    eret_take_s  = head_valid_s && head_s.eret && !exc_take_s && !int_take_s;
    retire_s     = head_valid_s && !exc_take_s && !int_take_s && !eret_take_s;
    pop_s        = retire_s && (!head_s.we || rf_ready);
    rf_we_s      = retire_s && head_s.we && rf_ready && (head_s.dest != 5'd0);
    flush_s      = exc_take_s || int_take_s || eret_take_s;
    ws_allowin   = (count_r < CNT_W'(DEPTH)) && !flush_s;
    push_s       = ms_to_ws_valid && ws_allowin;
  end

  // Exception/ERET outputs stay quiet unless the head actually traps.
  always_comb begin
    ex_valid    = exc_take_s || int_take_s;
    eret_valid  = eret_take_s;
    ex_bd       = 1'b0;
    ex_epc      = {DATA_W{1'b0}};
    ex_badvaddr = {DATA_W{1'b0}};
    if (exc_take_s) begin
      ex_code = head_s.exc;
    end else if (int_take_s) begin
      ex_code = INT;
    end else begin
      ex_code = NO_EX;
    end
    if (ex_valid) begin
      ex_bd       = head_s.slot;
      ex_epc      = epc_of(head_s);
      ex_badvaddr = head_s.badvaddr;
    end else begin
      ex_bd       = 1'b0;
    end
  end

  // RF write port driven from the head only when it really writes.
  always_comb begin
    rf_waddr_s = 5'd0;
    rf_wdata_s = {DATA_W{1'b0}};
    if (rf_we_s) begin
      rf_waddr_s = head_s.dest;
      rf_wdata_s = head_s.result;
    end else begin
      rf_waddr_s = 5'd0;
    end
  end

  assign ws_to_rf_bus_s = {rf_we_s, rf_waddr_s, rf_wdata_s};
  assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus_s;
  assign occupancy = count_r;

  // Queue control state: pointers, count and per-slot valids.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      valid_r <= {DEPTH{1'b0}};
    end else if (flush_s) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      valid_r <= {DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        tail_r          <= tail_r + PTR_W'(1'b1);
        valid_r[tail_r] <= 1'b1;
      end
      if (pop_s) begin
        head_r          <= head_r + PTR_W'(1'b1);
        valid_r[head_r] <= 1'b0;
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Entry payload storage; qualified by valid_r so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      entries_r[tail_r] <= in_entry_s;
    end
  end

  // Flatten the fields the forwarding search needs.
  always_comb begin
    fwd_en_s      = {DEPTH{1'b0}};
    dest_flat_s   = {(DEPTH*5){1'b0}};
    result_flat_s = {(DEPTH*DATA_W){1'b0}};
    mfc0_flat_s   = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      fwd_en_s[i]                  = valid_r[i] && entries_r[i].we;
      dest_flat_s[i*5 +: 5]        = entries_r[i].dest;
      result_flat_s[i*DATA_W +: DATA_W] = entries_r[i].result;
      mfc0_flat_s[i]               = entries_r[i].mfc0;
    end
  end

  for (genvar p = 0; p < NUM_FWD; p++) begin : g_fwd
    wb_fwd_match #(
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W),
      .DATA_W (DATA_W)
    ) u_match (
      .match_en (fwd_en_s),
      .dest     (dest_flat_s),
      .result   (result_flat_s),
      .mfc0     (mfc0_flat_s),
      .head_ptr (head_r),
      .raddr    (fwd_raddr[p*5 +: 5]),
      .hit      (fwd_hit[p]),
      .data     (fwd_data[p*DATA_W +: DATA_W]),
      .stall    (fwd_stall[p])
    );
  end

`ifdef WB_TRACE_EN
  // Trace mirrors the retire; pc follows the head whenever one exists.
  always_comb begin
    debug_wb_rf_wen   = {4{rf_we_s}};
    debug_wb_rf_wnum  = rf_waddr_s;
    debug_wb_rf_wdata = rf_wdata_s;
    if (head_valid_s) begin
      debug_wb_pc = head_s.pc;
    end else begin
      debug_wb_pc = {DATA_W{1'b0}};
    end
  end
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed self-checking bench for wb_retire_queue.
module tb_wb_retire_queue;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int NUM_FWD = 2;

  logic                      clk;
  logic                      resetn;
  logic                      ms_to_ws_valid;
  logic                      ws_allowin;
  logic [DATA_W-1:0]         in_pc;
  logic                      in_we;
  logic [4:0]                in_dest;
  logic [DATA_W-1:0]         in_result;
  logic [4:0]                in_exc;
  logic                      in_slot;
  logic                      in_eret;
  logic                      in_mfc0;
  logic [DATA_W-1:0]         in_badvaddr;
  logic                      int_pending;
  logic                      rf_ready;
  logic                      rf_we;
  logic [4:0]                rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic                      ex_valid;
  logic [4:0]                ex_code;
  logic [DATA_W-1:0]         ex_epc;
  logic [DATA_W-1:0]         ex_badvaddr;
  logic                      ex_bd;
  logic                      eret_valid;
  logic [NUM_FWD*5-1:0]      fwd_raddr;
  logic [NUM_FWD-1:0]        fwd_hit;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [NUM_FWD-1:0]        fwd_stall;
`ifdef WB_TRACE_EN
  logic [DATA_W-1:0]         debug_wb_pc;
  logic [3:0]                debug_wb_rf_wen;
  logic [4:0]                debug_wb_rf_wnum;
  logic [DATA_W-1:0]         debug_wb_rf_wdata;
`endif
  logic [2:0]                occupancy;

  int errors = 0;
  int checks = 0;

  wb_retire_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ws_allowin     (ws_allowin),
    .in_pc          (in_pc),
    .in_we          (in_we),
    .in_dest        (in_dest),
    .in_result      (in_result),
    .in_exc         (in_exc),
    .in_slot        (in_slot),
    .in_eret        (in_eret),
    .in_mfc0        (in_mfc0),
    .in_badvaddr    (in_badvaddr),
    .int_pending    (int_pending),
    .rf_ready       (rf_ready),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .ex_valid       (ex_valid),
    .ex_code        (ex_code),
    .ex_epc         (ex_epc),
    .ex_badvaddr    (ex_badvaddr),
    .ex_bd          (ex_bd),
    .eret_valid     (eret_valid),
    .fwd_raddr      (fwd_raddr),
    .fwd_hit        (fwd_hit),
    .fwd_data       (fwd_data),
    .fwd_stall      (fwd_stall),
`ifdef WB_TRACE_EN
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
`endif
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                      input logic [31:0] res, input logic [4:0] exc, input logic slot,
                      input logic eret, input logic mfc0, input logic [31:0] bva);
    in_pc = pc; in_we = we; in_dest = dest; in_result = res; in_exc = exc;
    in_slot = slot; in_eret = eret; in_mfc0 = mfc0; in_badvaddr = bva;
    ms_to_ws_valid = 1'b1;
    @(posedge clk);
    #1;
    ms_to_ws_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; ms_to_ws_valid = 1'b0; in_pc = 32'd0; in_we = 1'b0; in_dest = 5'd0;
    in_result = 32'd0; in_exc = 5'h1F; in_slot = 1'b0; in_eret = 1'b0; in_mfc0 = 1'b0;
    in_badvaddr = 32'd0; int_pending = 1'b0; rf_ready = 1'b0; fwd_raddr = 10'd0;
    #1 resetn = 1'b0;
    #2;
    chk("reset_allowin", ws_allowin, 1);
    chk("reset_occ", occupancy, 0);
    chk("reset_excode", ex_code, 5'h1F);
    chk("reset_exvalid", ex_valid, 0);
    chk("reset_rfwe", rf_we, 0);
    #4 resetn = 1'b1;
    next_cycle();

    // Fill with rf_ready low, then drain in order.
    for (int i = 0; i < 4; i++)
      push(32'h100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h11 * 32'(i + 1), 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("full_occ", occupancy, 4);
    chk("full_allowin", ws_allowin, 0);
    chk("full_hold_rfwe", rf_we, 0);
    rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_rfwe", rf_we, 1);
      chk("drain_waddr", rf_waddr, i + 1);
      chk("drain_wdata", rf_wdata, 32'h11 * (i + 1));
      next_cycle();
    end
    chk("drain_occ", occupancy, 0);

    // Forwarding: youngest wins, mfc0 stalls, raddr 0 never hits.
    rf_ready = 1'b0;
    push(32'h1FC, 1'b1, 5'd0, 32'hDEAD, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h200, 1'b1, 5'd5, 32'hA, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h204, 1'b1, 5'd5, 32'hB, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h208, 1'b1, 5'd6, 32'h66, 5'h1F, 1'b0, 1'b0, 1'b1, 32'd0);
    fwd_raddr = {5'd6, 5'd5};
    #1;
    chk("fwd5_hit", fwd_hit[0], 1);
    chk("fwd5_data", fwd_data[31:0], 32'hB);
    chk("fwd5_stall", fwd_stall[0], 0);
    chk("fwd6_hit", fwd_hit[1], 1);
    chk("fwd6_data", fwd_data[63:32], 32'h66);
    chk("fwd6_stall", fwd_stall[1], 1);
    fwd_raddr = {5'd0, 5'd5};
    #1;
    chk("fwd0_hit", fwd_hit[1], 0);
    rf_ready = 1'b1;
    #1;
    chk("dest0_rfwe", rf_we, 0);
    repeat (4) next_cycle();
    chk("fwd_drain_occ", occupancy, 0);
    fwd_raddr = 10'd0;

    // Exception behind two older writes.
    rf_ready = 1'b0;
    push(32'h300, 1'b1, 5'd8, 32'h88, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h304, 1'b1, 5'd9, 32'h99, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'hBFC00100, 1'b1, 5'd10, 32'hAA, 5'h04, 1'b1, 1'b0, 1'b0, 32'h3);
    #1;
    chk("exc_occ", occupancy, 3);
    rf_ready = 1'b1;
    #1;
    chk("exc_old1_waddr", rf_waddr, 8);
    next_cycle(); #1;
    chk("exc_old2_rfwe", rf_we, 1);
    chk("exc_old2_waddr", rf_waddr, 9);
    next_cycle(); #1;
    chk("exc_valid", ex_valid, 1);
    chk("exc_code", ex_code, 5'h04);
    chk("exc_epc", ex_epc, 32'hBFC000FC);
    chk("exc_bd", ex_bd, 1);
    chk("exc_badvaddr", ex_badvaddr, 32'h3);
    chk("exc_no_rfwe", rf_we, 0);
    chk("exc_allowin", ws_allowin, 0);
    next_cycle(); #1;
    chk("exc_flush_occ", occupancy, 0);
    chk("exc_pulse_end", ex_valid, 0);

    // ERET at head with two younger entries.
    rf_ready = 1'b0;
    push(32'h400, 1'b1, 5'd13, 32'hD0, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h404, 1'b0, 5'd0, 32'h0, 5'h1F, 1'b0, 1'b1, 1'b0, 32'd0);
    push(32'h408, 1'b1, 5'd11, 32'hB1, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h40C, 1'b1, 5'd12, 32'hC1, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("eret_occ", occupancy, 4);
    chk("eret_not_yet", eret_valid, 0);
    rf_ready = 1'b1;
    #1;
    chk("eret_old_waddr", rf_waddr, 13);
    next_cycle(); #1;
    chk("eret_valid", eret_valid, 1);
    chk("eret_no_rfwe", rf_we, 0);
    chk("eret_no_ex", ex_valid, 0);
    next_cycle(); #1;
    chk("eret_pulse_end", eret_valid, 0);
    chk("eret_flush_occ", occupancy, 0);
    chk("eret_young_rfwe", rf_we, 0);
    fwd_raddr = {5'd12, 5'd11};
    #1;
    chk("eret_fwd_gone", fwd_hit, 0);
    fwd_raddr = 10'd0;

    // Interrupt: ignored while empty, taken at the next head.
    int_pending = 1'b1;
    #1;
    chk("int_empty", ex_valid, 0);
    push(32'h500, 1'b1, 5'd7, 32'h77, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk("int_valid", ex_valid, 1);
    chk("int_code", ex_code, 5'h00);
    chk("int_no_rfwe", rf_we, 0);
    chk("int_epc", ex_epc, 32'h500);
    next_cycle();
    int_pending = 1'b0;
    #1;
    chk("int_flush_occ", occupancy, 0);
    chk("int_after_rfwe", rf_we, 0);

    // Asynchronous reset mid-cycle with entries queued.
    rf_ready = 1'b0;
    push(32'h600, 1'b1, 5'd14, 32'hE0, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h604, 1'b1, 5'd15, 32'hF0, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h608, 1'b1, 5'd16, 32'h10, 5'h1F, 1'b0, 1'b0, 1'b0, 32'd0);
    fwd_raddr = {5'd0, 5'd15};
    #1;
    chk("pre_rst_occ", occupancy, 3);
    chk("pre_rst_hit", fwd_hit[0], 1);
    #1 resetn = 1'b0;
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_allowin", ws_allowin, 1);
    chk("rst_hit", fwd_hit[0], 0);
    chk("rst_excode", ex_code, 5'h1F);
    resetn = 1'b1;
    next_cycle();
    chk("post_rst_occ", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
